servo_slew_sequencer: RTL

//  Sequences position commands for the servo PWM datapath (PWM_1000, 50 Hz).

---
 rtl/servo_slew_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/servo_slew_sequencer.sv
// Servo position sequencer: accepts clamped duty targets, slews one count per tick,
// dwells for settling, and updates the PWM duty only on frame boundaries.
module servo_slew_sequencer #(
    parameter int DUTY_W      = 10,
    parameter int DUTY_MIN    = 28,
    parameter int DUTY_MAX    = 125,
    parameter int DUTY_RESET  = 77,
    parameter int STEP_DIV    = 2_000_000,
    parameter int DWELL_TICKS = 25
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_abort,
    input  logic              frame_start,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              clamp_err,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int DW_W  = $clog2(DWELL_TICKS) + 1;

    localparam logic [DUTY_W-1:0] MIN_D   = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] MAX_D   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] RESET_D = DUTY_W'(DUTY_RESET);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(STEP_DIV - 1);
    localparam logic [DW_W-1:0]   LAST_DWELL = DW_W'(DWELL_TICKS - 1);

    // state_dbg encoding: 0 = IDLE, 1 = SLEW, 2 = DWELL.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLEW  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DUTY_W-1:0] pos, pos_next;
    logic [DUTY_W-1:0] target, target_next;
    logic [DW_W-1:0]   dwell_cnt, dwell_next;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              accept;
    logic              cmd_low, cmd_high;
    logic [DUTY_W-1:0] cmd_clamped;
    logic [DUTY_W-1:0] pos_step;

    // Handshake: cmd_ready is a pure function of state and cmd_abort; a command
    // transfers on a rising clk edge with cmd_valid & cmd_ready, and cmd_duty is
    // sampled only on that edge. cmd_valid may be held across busy periods.
    assign cmd_ready = (state == S_IDLE) & ~cmd_abort;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    assign cmd_low     = (cmd_duty < MIN_D);
    assign cmd_high    = (cmd_duty > MAX_D);
    assign cmd_clamped = cmd_low ? MIN_D : (cmd_high ? MAX_D : cmd_duty);

    assign tick     = (tick_cnt == LAST_CNT);
    assign pos_step = (target > pos) ? pos + 1'b1 : pos - 1'b1;

    always_comb begin
        state_next  = state;
        pos_next    = pos;
        target_next = target;
        dwell_next  = dwell_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    target_next = cmd_clamped;
                    dwell_next  = '0;
                    state_next  = (cmd_clamped == pos) ? S_DWELL : S_SLEW;
                end
            end
            S_SLEW: begin
                if (cmd_abort) begin
                    target_next = pos;
                    state_next  = S_IDLE;
                end else if (tick) begin
                    pos_next = pos_step;
                    if (pos_step == target) begin
                        dwell_next = '0;
                        state_next = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (cmd_abort) begin
                    target_next = pos;
                    state_next  = S_IDLE;
                end else if (tick) begin
                    if (dwell_cnt == LAST_DWELL) begin
                        state_next = S_IDLE;
                    end else begin
                        dwell_next = dwell_cnt + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state     <= S_IDLE;
            pos       <= RESET_D;
            target    <= RESET_D;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            pos       <= pos_next;
            target    <= target_next;
            dwell_cnt <= dwell_next;
        end
    end

    // Tick phase restarts on every accept so the first step lands STEP_DIV cycles later.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            tick_cnt <= '0;
        end else if (accept || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            clamp_err <= 1'b0;
        end else begin
            clamp_err <= accept & (cmd_low | cmd_high);
        end
    end

    // Sampling pos (not pos_next) gives the pre-tick value when a tick shares the edge.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            duty_out <= RESET_D;
        end else if (frame_start) begin
            duty_out <= pos;
        end
    end

endmodule
